mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single memory request channel.
//
// Port 0 (instruction fetch) and port 1 (load/store) request the memory. One
// transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//
// Handshake semantics:
//   A requester raises reqN with wrN/addrN/wr_dataN and holds them stable
//   until gntN. A request is captured at a clock edge in IDLE only when
//   from_mem_ready is high; the captured operands drive to_mem_addr and
//   to_mem_wr_data from ISSUE through DONE. to_mem_rd/to_mem_wr pulse for the
//   single ISSUE cycle. A read completes on the first WAIT cycle with
//   from_mem_rd_data_valid; a write completes on the first WAIT cycle, from
//   the second one on, with from_mem_ready high. doneN pulses for one cycle
//   in DONE; err pulses together with done when WAIT ran into TIMEOUT.
//
// Parameters: TIMEOUT (max WAIT cycles), ADDR_W (address/data width).
// Ports:
//   clk, rst (async, active high)
//   req0/req1, wr0/wr1, addr0/addr1, wr_data0/wr_data1   requester inputs
//   gnt0/gnt1, done0/done1, rd_data0/rd_data1, err, busy requester outputs
//   to_mem_rd, to_mem_wr, to_mem_addr, to_mem_wr_data    memory request
//   from_mem_ready, from_mem_rd_data, from_mem_rd_data_valid  memory response
//   state_dbg                                            current FSM state
//
// Build option: MEM_ARBITER_RR_EN selects round-robin arbitration on
// simultaneous requests; without it port 1 always wins a collision.

module mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd64,
  parameter int         ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] wr_data0,
  input  logic [ADDR_W-1:0] wr_data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [ADDR_W-1:0] rd_data0,
  output logic [ADDR_W-1:0] rd_data1,
  output logic              err,
  output logic              busy,
  output logic              to_mem_rd,
  output logic              to_mem_wr,
  output logic [ADDR_W-1:0] to_mem_addr,
  output logic [ADDR_W-1:0] to_mem_wr_data,
  input  logic              from_mem_ready,
  input  logic [ADDR_W-1:0] from_mem_rd_data,
  input  logic              from_mem_rd_data_valid,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q;    // 1 = port 1 owns the current transaction
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] data_q;
  logic [7:0]        cnt_q;      // WAIT cycles elapsed, saturating
  logic              err_q;
  logic [ADDR_W-1:0] rd_data0_q;
  logic [ADDR_W-1:0] rd_data1_q;

  logic capture;
  logic pick1;
  logic complete;
  logic timeout;

`ifdef MEM_ARBITER_RR_EN
  // Port preferred on the next collision; flips to the other port at each grant.
  logic prio_q;
  assign pick1 = req1 & (~req0 | prio_q);
`else
  assign pick1 = req1;
`endif

  assign capture = (state_q == S_IDLE) && (req0 || req1) && from_mem_ready;

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE:  if (capture) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // cnt_q == 0 is the first WAIT cycle, where a write may not complete.
        if (wr_q) complete = from_mem_ready && (cnt_q != 8'd0);
        else      complete = from_mem_rd_data_valid;
        // Timeout fires on the WAIT cycle whose count would reach TIMEOUT.
        timeout = !complete && (({1'b0, cnt_q} + 9'd1) >= {1'b0, TIMEOUT});
        if (complete || timeout) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      rd_data0_q <= '0;
      rd_data1_q <= '0;
`ifdef MEM_ARBITER_RR_EN
      prio_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (capture) begin
        owner_q <= pick1;
        wr_q    <= pick1 ? wr1 : wr0;
        addr_q  <= pick1 ? addr1 : addr0;
        data_q  <= pick1 ? wr_data1 : wr_data0;
`ifdef MEM_ARBITER_RR_EN
        prio_q  <= ~pick1;
`endif
      end
      if (state_q == S_ISSUE)
        cnt_q <= 8'd0;
      else if (state_q == S_WAIT && cnt_q != 8'hFF)
        cnt_q <= cnt_q + 8'd1;
      // Set only on the WAIT->DONE edge of a timeout, so it is high for DONE only.
      err_q <= timeout;
      if (state_q == S_WAIT && !wr_q && complete) begin
        if (owner_q) rd_data1_q <= from_mem_rd_data;
        else         rd_data0_q <= from_mem_rd_data;
      end
    end
  end

  // Pulses decode from the state register so reset clears them immediately.
  assign gnt0           = (state_q == S_ISSUE) && !owner_q;
  assign gnt1           = (state_q == S_ISSUE) &&  owner_q;
  assign to_mem_rd      = (state_q == S_ISSUE) && !wr_q;
  assign to_mem_wr      = (state_q == S_ISSUE) &&  wr_q;
  assign done0          = (state_q == S_DONE) && !owner_q;
  assign done1          = (state_q == S_DONE) &&  owner_q;
  assign err            = err_q;
  assign busy           = (state_q != S_IDLE);
  assign to_mem_addr    = addr_q;
  assign to_mem_wr_data = data_q;
  assign rd_data0       = rd_data0_q;
  assign rd_data1       = rd_data1_q;
  assign state_dbg      = state_q;

endmodule
